// File: rtl/ex_mem_elastic.sv
// EX/MEM pipeline register with valid/ready handshake and a two-entry skid buffer.
// State updates on the falling clock edge; reset is asynchronous and active-high.
module ex_mem_elastic #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 4,
  parameter int CNT_W       = 16,
  parameter int MASK_BUBBLE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_W-1:0]     ALUResult_in,
  input  logic                  memRead_in,
  input  logic                  memWrite_in,
  input  logic                  memToReg_in,
  input  logic [DATA_W-1:0]     registerFileDataB_in,
  input  logic [REG_ADDR_W-1:0] registerFileWrite_in,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_W-1:0]     ALUResult,
  output logic                  memRead,
  output logic                  memWrite,
  output logic                  memToReg,
  output logic [DATA_W-1:0]     registerFileDataB,
  output logic [REG_ADDR_W-1:0] registerFileWrite,
  output logic [CNT_W-1:0]      stallCount
);

  localparam int ENT_W = 2 * DATA_W + REG_ADDR_W + 3;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state_reg, state_next;
  logic [ENT_W-1:0]   head_reg, skid_reg, in_entry;
  logic [CNT_W-1:0]   stall_reg;
  logic               load_head_in, load_head_skid, load_skid;
  logic               accept, pop;

  logic [DATA_W-1:0]     head_alu, head_datab;
  logic [REG_ADDR_W-1:0] head_rw;
  logic                  head_mr, head_mw, head_m2r;

  assign in_entry = {ALUResult_in, registerFileDataB_in, registerFileWrite_in,
                     memRead_in, memWrite_in, memToReg_in};

  // Handshake flags come from registered state only, so ready never depends on outReady.
  assign outValid = (state_reg != EMPTY);
  assign inReady  = (state_reg != TWO);
  assign accept   = inValid & inReady;
  assign pop      = outValid & outReady;

  always_comb begin
    state_next     = state_reg;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: if (accept) begin
          state_next   = ONE;
          load_head_in = 1'b1;
        end
        ONE: begin
          if (accept && pop) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (pop) begin
            state_next = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_next     = ONE;
          load_head_skid = 1'b1;
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) state_reg <= EMPTY;
    else       state_reg <= state_next;
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      head_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_head_in)        head_reg <= in_entry;
      else if (load_head_skid) head_reg <= skid_reg;
      if (load_skid)           skid_reg <= in_entry;
    end
  end

  // Flush does not suppress counting: a stalled head still costs MEM that edge.
  always_ff @(negedge clock or posedge reset) begin
    if (reset)
      stall_reg <= '0;
    else if (outValid && !outReady && stall_reg != {CNT_W{1'b1}})
      stall_reg <= stall_reg + CNT_ONE;
  end

  assign stallCount = stall_reg;
  assign {head_alu, head_datab, head_rw, head_mr, head_mw, head_m2r} = head_reg;
  assign ALUResult         = head_alu;
  assign registerFileDataB = head_datab;

  generate
    if (MASK_BUBBLE != 0) begin : g_mask
      assign memRead           = head_mr  & outValid;
      assign memWrite          = head_mw  & outValid;
      assign memToReg          = head_m2r & outValid;
      assign registerFileWrite = outValid ? head_rw : '0;
    end else begin : g_nomask
      assign memRead           = head_mr;
      assign memWrite          = head_mw;
      assign memToReg          = head_m2r;
      assign registerFileWrite = head_rw;
    end
  endgenerate

endmodule

// File: tb/tb_ex_mem_elastic.sv
// Randomised plus directed scoreboard bench for ex_mem_elastic (CNT_W=4 so saturation is reachable).
module tb_ex_mem_elastic;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] ALUResult_in = '0;
  logic        memRead_in = 1'b0, memWrite_in = 1'b0, memToReg_in = 1'b0;
  logic [31:0] registerFileDataB_in = '0;
  logic [3:0]  registerFileWrite_in = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] ALUResult;
  logic        memRead, memWrite, memToReg;
  logic [31:0] registerFileDataB;
  logic [3:0]  registerFileWrite;
  logic [3:0]  stallCount;

  ex_mem_elastic #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(4), .MASK_BUBBLE(1)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .ALUResult_in(ALUResult_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
    .memToReg_in(memToReg_in), .registerFileDataB_in(registerFileDataB_in),
    .registerFileWrite_in(registerFileWrite_in),
    .outValid(outValid), .outReady(outReady),
    .ALUResult(ALUResult), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .registerFileDataB(registerFileDataB), .registerFileWrite(registerFileWrite),
    .stallCount(stallCount)
  );

  always #5 clock = ~clock;

  // Reference model: a FIFO of expected entries, an occupancy count and a saturating stall count.
  logic [70:0] exp_q[$];
  int          occ = 0;
  int          stall_m = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          pop_m, acc_m;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock period: drive on the rising edge, advance the model on the falling edge.
  task automatic cyc(input bit rs, input bit fl, input bit iv, input bit ordy,
                     input logic [31:0] alu, input logic [31:0] bd,
                     input logic [3:0] rw, input logic [2:0] ctl);
    @(posedge clock);
    reset = rs; flush = fl; inValid = iv; outReady = ordy;
    ALUResult_in = alu; registerFileDataB_in = bd; registerFileWrite_in = rw;
    {memRead_in, memWrite_in, memToReg_in} = ctl;
    if (rs) begin
      occ = 0; stall_m = 0; exp_q.delete();
    end
    @(negedge clock);
    if (!rs) begin
      if (occ != 0 && !ordy) stall_m = (stall_m == 15) ? 15 : stall_m + 1;
      if (fl) begin
        occ = 0;
        exp_q.delete();
      end else begin
        pop_m = (occ != 0) && ordy;
        acc_m = iv && (occ < 2);
        if (acc_m) exp_q.push_back({alu, bd, rw, ctl});
        occ = occ - int'(pop_m) + int'(acc_m);
      end
    end
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 1'b0, 1'b0, ordy, 32'h0, 32'h0, 4'h0, 3'b000);
  endtask

  task automatic offer(input bit ordy, input logic [31:0] alu);
    cyc(1'b0, 1'b0, 1'b1, ordy, alu, ~alu, alu[3:0], alu[2:0] | 3'b010);
  endtask

  // Monitor: checks handshake/counter every cycle and pops the scoreboard on each consumption.
  logic [70:0] got;
  always @(posedge clock) begin
    #1;
    chk("out_valid", 128'(outValid), 128'(occ != 0));
    chk("in_ready", 128'(inReady), 128'(occ != 2));
    chk("stall_count", 128'(stallCount), 128'(stall_m));
    if (!outValid)
      chk("bubble_mask", 128'({memRead, memWrite, memToReg, registerFileWrite}), 128'(0));
    if (outValid && outReady) begin
      got = {ALUResult, registerFileDataB, registerFileWrite, memRead, memWrite, memToReg};
      if (exp_q.size() == 0) begin
        chk("unexpected_entry", 128'(got), 128'(0));
      end else begin
        chk("entry", 128'(got), 128'(exp_q[0]));
        $display("pop alu=%08h datab=%08h rd=%0d ctl=%b%b%b", ALUResult, registerFileDataB,
                 registerFileWrite, memRead, memWrite, memToReg);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    chk("reset_alu", 128'(ALUResult), 128'(0));
    idle(1'b1);

    // Streaming at full throughput
    offer(1'b1, 32'h10);
    offer(1'b1, 32'h20);
    offer(1'b1, 32'h30);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure into the skid entry; 0xC must be ignored
    offer(1'b0, 32'hA);
    offer(1'b0, 32'hB);
    offer(1'b0, 32'hC);
    offer(1'b1, 32'hC);
    idle(1'b1);
    idle(1'b1);

    // Flush while full with a new offer present
    offer(1'b0, 32'hE1);
    offer(1'b0, 32'hE2);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'hD, 32'hD, 4'hD, 3'b010);
    idle(1'b0);
    idle(1'b1);

    // Stall counter saturation
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    offer(1'b0, 32'h55);
    for (int i = 0; i < 20; i++) idle(1'b0);
    chk("stall_saturated", 128'(stallCount), 128'(15));
    idle(1'b0);
    chk("stall_held", 128'(stallCount), 128'(15));
    idle(1'b1);

    // Asynchronous reset in the middle of a stream
    offer(1'b0, 32'h71);
    offer(1'b0, 32'h72);
    @(posedge clock);
    #3;
    reset = 1'b1;
    occ = 0; stall_m = 0; exp_q.delete();
    #1;
    chk("areset_out_valid", 128'(outValid), 128'(0));
    chk("areset_rd", 128'(registerFileWrite), 128'(0));
    chk("areset_stall", 128'(stallCount), 128'(0));
    chk("areset_in_ready", 128'(inReady), 128'(1));
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      cyc(1'b0, ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60),
          ($urandom_range(0, 99) < 65), $urandom, $urandom,
          4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    end

    // Drain
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
